// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory side of the CPU load/store interface. It accepts one request per
// handshake, stalls for LATENCY wait-state cycles, then commits the store
// (with byte-lane enables) or fetches the load word, and presents the result
// through a response handshake. Only one request is ever outstanding.
//
// Handshake rules:
//   A request transfers on a rising edge where req_valid=1 and req_ready=1.
//   A response transfers on a rising edge where resp_valid=1 and
//   resp_ready=1. While resp_valid=1 the response fields are held stable.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset; also clears the memory array
//   req_valid   request present
//   req_ready   responder can accept a request (high only in IDLE)
//   req_write   1 = store, 0 = load
//   req_addr    byte address; word index = req_addr[31:2]
//   req_wdata   store data
//   req_wstrb   byte-lane enables for stores
//   resp_valid  response available
//   resp_ready  CPU accepts the response
//   resp_rdata  load data; 0 for stores and for errors
//   resp_err    request was misaligned or out of range
//   dbg_state   current FSM state, for observation only
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        write_q, write_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          err;
    logic          mem_we;
    logic [31:0]   mem_wword;

    // Index and error are derived from the latched address, so they are
    // stable for the whole time the request sits in WAIT.
    assign idx = addr_q[AW+1:2];
    assign err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));

    // Merge the enabled store lanes into the current word contents.
    always_comb begin
        mem_wword = mem_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                mem_wword[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        write_d      = write_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    write_d     = req_write;
                    cnt_d       = 4'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    if (err) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (write_q) begin
                        mem_we       = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        // Read returns the word as it was before this edge.
                        resp_rdata_d = mem_q[idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    // Ready returns one cycle after consumption, so a request
                    // can never be taken on the consuming edge.
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            write_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            write_q      <= write_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (mem_we) begin
                mem_q[idx] <= mem_wword;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Drives directed and randomized load/store traffic into dmem_responder and
// compares every response, its latency and the handshake signals against a
// transaction-level memory model held in a plain array.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [1:0]  dbg_idle, dbg_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // Transaction-level reference: one request in, {err, rdata} out.
  task automatic model_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, output logic [31:0] rd, output logic e);
    int unsigned w;
    w  = a >> 2;
    e  = (a % 4 != 0) || (w >= DEPTH);
    rd = 32'h0;
    if (!e) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (st[i]) model_mem[w][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = model_mem[w];
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic junk_request();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom() & 32'h0000_03FC;
    req_wdata = $urandom();
    req_wstrb = 4'($urandom_range(0, 15));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  // One full transaction: request, latency check, optional backpressure,
  // response check and return to idle. got_rd returns the observed data.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int hold, output logic [31:0] got_rd);
    logic [31:0] exp_rd;
    logic        exp_e;
    int          lat;
    model_req(wr, a, wd, st, exp_rd, exp_e);
    exp_q.push_back(exp_rd);
    @(negedge clk);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    dbg_idle   = dbg_state;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = wd;
    req_wstrb  = st;
    @(negedge clk);
    dbg_wait  = dbg_state;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      check("wait_req_ready", {31'b0, req_ready}, 32'd0);
      junk_request();
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LAT);
    exp_rd = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_err", {31'b0, resp_err}, {31'b0, exp_e});
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      junk_request();
      @(negedge clk);
    end
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", {31'b0, resp_err}, {31'b0, exp_e});
    got_rd     = resp_rdata;
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    check("done_valid", {31'b0, resp_valid}, 32'd0);
    check("done_rdata", resp_rdata, 32'h0);
    check("done_err", {31'b0, resp_err}, 32'd0);
    check("done_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] addr_pool [8];
    logic        seen;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_wstrb = 4'h0; resp_ready = 1'b0;
    model_clear();

    // Reset then idle.
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);

    // Store then load.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check("store_load", rd, 32'hDEADBEEF);
    check("dbg_state_moves", {31'b0, dbg_idle != dbg_wait}, 32'd1);

    // Byte lanes.
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check("lane_merge", rd, 32'h11BB33DD);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check("wstrb_zero_noop", rd, 32'h11BB33DD);

    // Errors.
    do_req(1'b1, 32'h0, 32'hCAFE0000, 4'hF, 0, rd);
    do_req(1'b1, 32'h3FC, 32'hCAFE03FC, 4'hF, 0, rd);
    do_req(1'b0, 32'h13, 32'h0, 4'h0, 0, rd);
    do_req(1'b1, 32'h400, 32'h12345678, 4'hF, 0, rd);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
    check("oob_keep_0", rd, 32'hCAFE0000);
    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd);
    check("oob_keep_3fc", rd, 32'hCAFE03FC);

    // Backpressure.
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd);
    check("bp_load", rd, 32'hDEADBEEF);

    // Async reset in WAIT: the store must never commit.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8;
    req_wdata = 32'h5A5A5A5A; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b0;
    #1 check("wait_rst_ready", {31'b0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    rst = 1'b1;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("wait_rst_no_resp", {31'b0, seen}, 32'd0);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 0, rd);
    check("wait_rst_no_write", rd, 32'h0);

    // Async reset in RESP: response dropped, memory cleared.
    do_req(1'b1, 32'h30, 32'h77777777, 4'hF, 0, rd);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h34;
    req_wdata = 32'h99999999; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    check("resp_rst_pre_valid", {31'b0, resp_valid}, 32'd1);
    #1 rst = 1'b0;
    #1 check("resp_rst_valid", {31'b0, resp_valid}, 32'd0);
    apply_reset();
    do_req(1'b0, 32'h34, 32'h0, 4'h0, 0, rd);
    check("resp_rst_cleared", rd, 32'h0);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, rd);
    check("resp_rst_cleared2", rd, 32'h0);

    // Randomized traffic against the model.
    addr_pool[0] = 32'h0;   addr_pool[1] = 32'h4;   addr_pool[2] = 32'h3FC;
    addr_pool[3] = 32'h400; addr_pool[4] = 32'h1;   addr_pool[5] = 32'h102;
    addr_pool[6] = 32'h80;  addr_pool[7] = 32'hFFFF_FFFC;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) a = addr_pool[$urandom_range(0, 7)];
      else a = $urandom() & 32'h0000_00FC;
      do_req(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
